// File: rtl/rv32i_pkg.sv
// rv32i: shared RV32I memory-op types and the byte-lane / load-extension helpers
package rv32i;
    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_e;

    typedef enum logic [2:0] {
        W_BYTE   = 3'd0,
        W_HALF   = 3'd1,
        W_WORD   = 3'd2,
        W_BYTE_U = 3'd4,
        W_HALF_U = 3'd5
    } mem_width_e;

    // Undefined width encodings count as misaligned so they never touch the array
    function automatic logic misaligned(mem_width_e w, logic [1:0] off);
        case (w)
            W_BYTE, W_BYTE_U: return 1'b0;
            W_HALF, W_HALF_U: return off[0];
            W_WORD:           return off != 2'b00;
            default:          return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(mem_width_e w, logic [1:0] off);
        case (w)
            W_BYTE, W_BYTE_U: return 4'b0001 << off;
            W_HALF, W_HALF_U: return off[1] ? 4'b1100 : 4'b0011;
            W_WORD:           return 4'b1111;
            default:          return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(mem_width_e w, logic [31:0] d);
        case (w)
            W_BYTE, W_BYTE_U: return {4{d[7:0]}};
            W_HALF, W_HALF_U: return {2{d[15:0]}};
            default:          return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(mem_width_e w, logic [31:0] word, logic [1:0] off);
        logic [31:0] s;
        s = word >> {off, 3'b000};
        case (w)
            W_BYTE:   return {{24{s[7]}}, s[7:0]};
            W_BYTE_U: return {24'd0, s[7:0]};
            W_HALF:   return {{16{s[15]}}, s[15:0]};
            W_HALF_U: return {16'd0, s[15:0]};
            W_WORD:   return word;
            default:  return 32'd0;
        endcase
    endfunction
endpackage

// File: rtl/data_ram_array.sv
// data_ram_array: single-port byte-lane RAM; synchronous write, registered read held between loads
module data_ram_array #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic                           we,
    input  logic [3:0]                     be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end else if (en) begin
            rdata_q <= mem[idx];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/data_ram.sv
// data_ram: valid/ready load/store RAM with alignment and range checks.
// DATA_RAM_OUTREG_EN adds a registered output stage (latency 2, full throughput).
module data_ram
    import rv32i::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  mem_op_e     mem_op,
    input  mem_width_e  mem_width,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic        is_ld, is_st, bad, acc, arr_en, out_ready;
    logic [31:0] arr_rdata, fmt;
    logic        v1_q, v1_d, err1_q, err1_d, ld1_q, ld1_d;
    mem_width_e  w1_q, w1_d;
    logic [1:0]  off1_q, off1_d;

    data_ram_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (is_st),
        .be    (lane_mask(mem_width, addr[1:0])),
        .idx   (addr[AW+1:2]),
        .wdata (store_lanes(mem_width, wdata)),
        .rdata (arr_rdata)
    );

    // Stage 1 keeps the lane/width of the accepted load; the array output register holds the word
    always_comb begin
        is_ld     = mem_op == MEM_LOAD;
        is_st     = mem_op == MEM_STORE;
        bad       = (is_ld || is_st) && (misaligned(mem_width, addr[1:0]) || |addr[31:AW+2]);
        req_ready = !rst && (!v1_q || out_ready);
        acc       = req_valid && req_ready;
        arr_en    = acc && (is_ld || is_st) && !bad;
        v1_d      = acc || (v1_q && !out_ready);
        err1_d    = acc ? bad : err1_q;
        ld1_d     = acc ? is_ld && !bad : ld1_q;
        w1_d      = acc ? mem_width : w1_q;
        off1_d    = acc ? addr[1:0] : off1_q;
        fmt       = (v1_q && ld1_q) ? load_extend(w1_q, arr_rdata, off1_q) : 32'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            err1_q <= 1'b0;
            ld1_q  <= 1'b0;
            w1_q   <= W_WORD;
            off1_q <= 2'd0;
        end else begin
            v1_q   <= v1_d;
            err1_q <= err1_d;
            ld1_q  <= ld1_d;
            w1_q   <= w1_d;
            off1_q <= off1_d;
        end
    end

`ifdef DATA_RAM_OUTREG_EN
    logic        v2_q, v2_d, err2_q, err2_d;
    logic [31:0] rdata2_q, rdata2_d;

    always_comb begin
        out_ready = !v2_q || resp_ready;
        v2_d      = out_ready ? v1_q : v2_q;
        err2_d    = out_ready ? v1_q && err1_q : err2_q;
        rdata2_d  = out_ready ? fmt : rdata2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q     <= 1'b0;
            err2_q   <= 1'b0;
            rdata2_q <= 32'd0;
        end else begin
            v2_q     <= v2_d;
            err2_q   <= err2_d;
            rdata2_q <= rdata2_d;
        end
    end

    assign resp_valid = v2_q;
    assign resp_err   = err2_q;
    assign rdata      = rdata2_q;
`else
    assign out_ready  = resp_ready;
    assign resp_valid = v1_q;
    assign resp_err   = v1_q && err1_q;
    assign rdata      = fmt;
`endif
endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: directed vector table plus stall, latency and reset sequences for data_ram
module tb_data_ram;
    import rv32i::*;

`ifdef DATA_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    mem_op_e     mem_op = MEM_NOP;
    mem_width_e  mem_width = W_WORD;
    logic [31:0] addr = 32'd0, wdata = 32'd0, rdata;
    logic        resp_valid, resp_ready = 1'b1, resp_err;
    int          checks = 0, errors = 0;

    typedef struct {logic err; logic [31:0] rd;} exp_t;
    typedef struct {mem_op_e op; mem_width_e w; logic [31:0] a; logic [31:0] d; logic e; logic [31:0] r;} vec_t;
    exp_t exp_q[$];
    exp_t mon_e;
    vec_t tv[$];

    always #5 clk = ~clk;

    data_ram dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .mem_op(mem_op), .mem_width(mem_width), .addr(addr), .wdata(wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .rdata(rdata), .resp_err(resp_err)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    // In-order scoreboard: every consumed response is matched against the oldest accepted request
    initial forever begin
        @(negedge clk);
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got rdata %h err %b with nothing outstanding", rdata, resp_err);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_err", 32'(resp_err), 32'(mon_e.err));
                check("rdata", rdata, mon_e.rd);
            end
        end
    end

    task automatic send(mem_op_e op, mem_width_e w, logic [31:0] a, logic [31:0] d, logic e, logic [31:0] r);
        bit ok = 1'b0;
        req_valid = 1'b1;
        mem_op = op;
        mem_width = w;
        addr = a;
        wdata = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                exp_q.push_back('{e, r});
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready stayed %b for addr %h", req_ready, a);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_outstanding", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        #12;
        check("reset_resp_valid", 32'(resp_valid), 0);
        check("reset_resp_err", 32'(resp_err), 0);
        check("reset_rdata", rdata, 0);
        check("reset_req_ready", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        tv.push_back('{MEM_STORE, W_WORD,   32'h10,   32'hDEADBEEF, 1'b0, 32'h0});
        tv.push_back('{MEM_LOAD,  W_BYTE,   32'h11,   32'h0,        1'b0, 32'hFFFFFFBE});
        tv.push_back('{MEM_LOAD,  W_BYTE_U, 32'h11,   32'h0,        1'b0, 32'h000000BE});
        tv.push_back('{MEM_LOAD,  W_HALF,   32'h12,   32'h0,        1'b0, 32'hFFFFDEAD});
        tv.push_back('{MEM_LOAD,  W_HALF_U, 32'h12,   32'h0,        1'b0, 32'h0000DEAD});
        tv.push_back('{MEM_LOAD,  W_BYTE,   32'h10,   32'h0,        1'b0, 32'hFFFFFFEF});
        tv.push_back('{MEM_LOAD,  W_BYTE_U, 32'h13,   32'h0,        1'b0, 32'h000000DE});
        tv.push_back('{MEM_STORE, W_WORD,   32'h20,   32'hAAAAAAAA, 1'b0, 32'h0});
        tv.push_back('{MEM_STORE, W_HALF,   32'h22,   32'hFFFF1234, 1'b0, 32'h0});
        tv.push_back('{MEM_LOAD,  W_WORD,   32'h20,   32'h0,        1'b0, 32'h1234AAAA});
        tv.push_back('{MEM_LOAD,  W_WORD,   32'h13,   32'h0,        1'b1, 32'h0});
        tv.push_back('{MEM_STORE, W_HALF,   32'h21,   32'h5555,     1'b1, 32'h0});
        tv.push_back('{MEM_LOAD,  W_WORD,   32'h20,   32'h0,        1'b0, 32'h1234AAAA});
        tv.push_back('{MEM_LOAD,  W_WORD,   32'h1000, 32'h0,        1'b1, 32'h0});
        tv.push_back('{MEM_STORE, W_BYTE,   32'h1000, 32'h99,       1'b1, 32'h0});
        tv.push_back('{MEM_STORE, W_BYTE,   32'h23,   32'h00000077, 1'b0, 32'h0});
        tv.push_back('{MEM_LOAD,  W_WORD,   32'h20,   32'h0,        1'b0, 32'h7734AAAA});
        tv.push_back('{MEM_LOAD,  W_HALF,   32'h20,   32'h0,        1'b0, 32'hFFFFAAAA});
        tv.push_back('{MEM_LOAD,  W_HALF_U, 32'h22,   32'h0,        1'b0, 32'h00007734});
        tv.push_back('{MEM_STORE, W_WORD,   32'hFFC,  32'h01020304, 1'b0, 32'h0});
        tv.push_back('{MEM_LOAD,  W_WORD,   32'hFFC,  32'h0,        1'b0, 32'h01020304});
        tv.push_back('{mem_op_e'(2'd3), W_WORD, 32'h10, 32'h0,      1'b0, 32'h0});
        tv.push_back('{MEM_LOAD,  W_HALF,   32'h11,   32'h0,        1'b1, 32'h0});
        tv.push_back('{MEM_LOAD,  W_BYTE_U, 32'h1003, 32'h0,        1'b1, 32'h0});
        tv.push_back('{MEM_STORE, W_BYTE,   32'h12,   32'hFFFFFF80, 1'b0, 32'h0});
        tv.push_back('{MEM_LOAD,  W_WORD,   32'h10,   32'h0,        1'b0, 32'hDE80BEEF});
        for (int i = 0; i < tv.size(); i++)
            send(tv[i].op, tv[i].w, tv[i].a, tv[i].d, tv[i].e, tv[i].r);
        req_valid = 1'b0;
        drain();

        send(MEM_LOAD, W_WORD, 32'h10, 32'h0, 1'b0, 32'hDE80BEEF);
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("load_latency", n, LAT);
        drain();

        send(MEM_STORE, W_WORD, 32'h40, 32'hCAFEF00D, 1'b0, 32'h0);
        send(MEM_LOAD,  W_WORD, 32'h40, 32'h0,        1'b0, 32'hCAFEF00D);
        resp_ready = 1'b0;
        mem_op = MEM_LOAD;
        mem_width = W_HALF_U;
        addr = 32'h42;
        repeat (3) begin
            @(negedge clk);
            check("stall_req_ready", 32'(req_ready), 0);
            check("stall_resp_valid", 32'(resp_valid), 1);
            if (exp_q.size() != 0) begin
                check("stall_rdata", rdata, exp_q[0].rd);
                check("stall_resp_err", 32'(resp_err), 32'(exp_q[0].err));
            end
            @(posedge clk);
            #1;
        end
        resp_ready = 1'b1;
        send(MEM_LOAD, W_HALF_U, 32'h42, 32'h0, 1'b0, 32'h0000CAFE);
        send(MEM_LOAD, W_BYTE_U, 32'h41, 32'h0, 1'b0, 32'h000000F0);
        req_valid = 1'b0;
        drain();

        send(MEM_LOAD, W_WORD, 32'h40, 32'h0, 1'b0, 32'hCAFEF00D);
        req_valid = 1'b0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("pre_reset_resp_valid", 32'(resp_valid), 1);
        rst = 1'b1;
        #1;
        check("async_reset_resp_valid", 32'(resp_valid), 0);
        check("async_reset_rdata", rdata, 0);
        check("async_reset_resp_err", 32'(resp_err), 0);
        check("async_reset_req_ready", 32'(req_ready), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        check("post_reset_no_resp", 32'(resp_valid), 0);
        @(posedge clk);
        #1;
        send(MEM_LOAD, W_WORD, 32'h40, 32'h0, 1'b0, 32'hCAFEF00D);
        send(MEM_LOAD, W_WORD, 32'h20, 32'h0, 1'b0, 32'h7734AAAA);
        req_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words; it SHALL be a power of two, at least 4.
REQ-002 SHALL have localparam AW = $clog2(DEPTH_WORDS), meaning the word-index width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit: the request is present.
REQ-006 SHALL have port req_ready, output, 1 bit: the request is accepted this cycle.
REQ-007 SHALL have port mem_op, input, mem_op_e: MEM_LOAD or MEM_STORE; any other value is a no-op that still returns a response.
REQ-008 SHALL have port mem_width, input, mem_width_e: W_BYTE, W_HALF, W_WORD, W_BYTE_U or W_HALF_U.
REQ-009 SHALL have port addr, input, 32 bits: byte address.
REQ-010 SHALL have port wdata, input, 32 bits: store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1 bit: the response is present.
REQ-012 SHALL have port resp_ready, input, 1 bit: the consumer accepts the response.
REQ-013 SHALL have port rdata, output, 32 bits: load result, extended to 32 bits; 0 for a store, no-op or error.
REQ-014 SHALL have port resp_err, output, 1 bit: the request was misaligned or out of range.

Function
REQ-015 A request SHALL be accepted on a cycle where req_valid && req_ready; req_ready = !resp_valid || resp_ready (base build).
REQ-016 Each accepted request SHALL yield exactly one response, in order; base latency is 1 cycle (resp_valid high on the next edge).
REQ-017 While resp_valid && !resp_ready, rdata/resp_err SHALL hold stable and no new request SHALL be accepted.
REQ-018 Misaligned SHALL mean: HALF/HALF_U with addr[0]=1, or WORD with addr[1:0]!=0.
REQ-019 Out of range SHALL mean: addr[31:2] >= DEPTH_WORDS.
REQ-020 A misaligned or out-of-range store SHALL write nothing; any error response SHALL have resp_err=1 and rdata=0.
REQ-021 A store SHALL write only the addressed byte lanes: BYTE writes wdata[7:0] to lane addr[1:0]; HALF writes wdata[15:0] to lanes {addr[1],0}+{1,0}; WORD writes all lanes.
REQ-022 A load SHALL select its lane(s) by addr[1:0]; BYTE/HALF sign-extend, BYTE_U/HALF_U zero-extend.
REQ-023 A load accepted the cycle after a store to the same word SHALL return the post-store contents.
REQ-024 Memory SHALL be a single port, one access per cycle, with no read-during-write conflict.
REQ-025 A stalled response SHALL NOT be re-read from the array; the selected data SHALL be captured at acceptance.

Reset
REQ-026 Asserting rst SHALL force resp_valid=0, resp_err=0 and rdata=0 immediately; the array contents SHALL be retained and are not initialised.
REQ-027 A request in flight at reset SHALL be discarded with no response; a store accepted on an edge where rst is low SHALL complete.
REQ-028 req_ready SHALL be 1 while rst is high is irrelevant: no request SHALL be accepted while rst is high.

Configuration
REQ-029 Macro DATA_RAM_OUTREG_EN defined SHALL add a registered output stage, making latency 2; the design SHALL be a 2-entry pipeline with backpressure per stage and still sustain 1 request per cycle when resp_ready=1.
REQ-030 Without DATA_RAM_OUTREG_EN, latency SHALL be 1 per REQ-016.
REQ-031 The ordering and stall rules (REQ-016, REQ-017, REQ-023) SHALL hold in both builds.

Structure
REQ-032 mem_width_e SHALL be added to package rv32i next to mem_op_e.
REQ-033 Lane-mask and extension helper functions SHALL live in the rv32i package.
REQ-034 Sub-module data_ram_array SHALL hold the byte-enabled storage (4 byte lanes, synchronous write/read); data_ram SHALL hold the handshake, checks and formatting.

Verification
REQ-035 Store WORD 0xDEADBEEF at 0x10, then LOAD W_BYTE at 0x11 -> rdata=0xFFFFFFBE; W_BYTE_U at 0x11 -> 0x000000BE; W_HALF at 0x12 -> 0xFFFFDEAD.
REQ-036 Store HALF 0x1234 at 0x22 over 0xAAAAAAAA at 0x20 -> W_WORD load at 0x20 returns 0x1234AAAA.
REQ-037 LOAD W_WORD at 0x13 -> resp_err=1, rdata=0; STORE W_HALF at 0x21 -> resp_err=1 and word 0x20 unchanged.
REQ-038 With DEPTH_WORDS=1024, LOAD at 0x1000 -> resp_err=1.
REQ-039 Back-to-back store then load of the same word with resp_ready=1 -> the load returns the new data; then resp_ready=0 for 3 cycles -> req_ready=0 and rdata stable; next response follows in order.
REQ-040 Assert rst mid-stream with resp_valid=1 -> resp_valid=0 in the same cycle; data stored before reset is readable after reset.
